// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide engine: op codes, FSM states and
// the default operand width.
package muldiv_unit_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and record the quotient bit.
module muldiv_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // The quotient register still holds the unconsumed dividend bits in its MSBs.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {2'b00, i_div});
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_div};

    always_comb begin
        o_rem = w_shift[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            o_rem = w_diff;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine feeding the HI/LO register: 32-step
// shift-add multiply, 32-step restoring divide, and MTHI/MTLO pass-through.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [1:0]         we,
    output logic [2*WIDTH-1:0] hilo_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic               r_sa, r_sb, r_bz;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo, r_div;
    logic [2*WIDTH-1:0] r_hilo;

    logic               w_accept;
    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_q, w_r;

    // Magnitude of the most negative value wraps to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign w_sa    = is_signed_op(op) & a[WIDTH-1];
    assign w_sb    = is_signed_op(op) & b[WIDTH-1];
    assign w_mag_a = w_sa ? (~a + 1'b1) : a;
    assign w_mag_b = w_sb ? (~b + 1'b1) : b;
    assign w_accept = start && !cancel && (r_state == S_IDLE) && (op <= OP_MTLO);

    muldiv_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nx),
        .o_quo (w_quo_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bz     <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_hilo   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_bz     <= (b == '0);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_rem    <= '0;
                        r_quo    <= w_mag_a;
                        r_div    <= w_mag_b;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == OP_MULT || r_op == OP_MULTU) begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                    end
                end
                S_DONE: begin
                    if (!cancel) begin
                        r_hilo <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign fix-up is applied only when the final {HI,LO} word is formed.
    always_comb begin
        w_result = '0;
        w_q      = r_quo;
        w_r      = r_rem[WIDTH-1:0];
        if (r_sa ^ r_sb) begin
            w_q = ~r_quo + 1'b1;
        end
        if (r_sa) begin
            w_r = ~r_rem[WIDTH-1:0] + 1'b1;
        end
        case (r_op)
            OP_MULT, OP_MULTU: w_result = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
            OP_DIV, OP_DIVU:   w_result = r_bz ? {r_a, {WIDTH{1'b1}}} : {w_r, w_q};
            OP_MTHI, OP_MTLO:  w_result = {r_a, r_a};
            default:           w_result = '0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        we       = 2'b00;
        hilo_out = r_hilo;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_next = S_CALC;
                        OP_MTHI, OP_MTLO:                   w_next = S_DONE;
                        default:                            w_next = S_IDLE;
                    endcase
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                w_next = S_IDLE;
                if (!cancel) begin
                    done     = 1'b1;
                    hilo_out = w_result;
                    case (r_op)
                        OP_MTHI: we = 2'b10;
                        OP_MTLO: we = 2'b01;
                        default: we = 2'b11;
                    endcase
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (cancel) begin
            w_next = S_IDLE;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide engine that produces the HI/LO write stream for the HI/LO register.
- Accepts one operation per start pulse from the execute stage.
- Computes MULT/MULTU by iterative shift-add and DIV/DIVU by restoring division, 32 iterations each.
- Handles MTHI/MTLO pass-through.
- Drives a 2-bit write enable plus 64-bit {HI,LO} data for exactly one cycle per completed operation.
- Asserts busy so the pipeline can stall mfhi/mflo and further muldiv issue.

Parameters:
WIDTH, 32, operand width; only 32 is supported and verified. HI/LO data is 2*WIDTH.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only in IDLE
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source)
b  input  WIDTH  rt operand (divisor / multiplier)
cancel  input  1  exception flush; aborts any in-flight op with no write
busy  output  1  high in CALC and DONE
done  output  1  one-cycle completion pulse, coincident with we
we  output  2  [1]=HI write, [0]=LO write; nonzero only in DONE
hilo_out  output  2*WIDTH  {HI,LO} write data; valid whenever we!=0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE, counter=0, all datapath registers 0.
  - busy=0, done=0, we=2'b00, hilo_out=0.
  - Reset mid-operation aborts it with no write.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 and cancel=0 with op in 0-3: latch op, a and b; take magnitudes of a and b for signed ops and record sign bits; cnt=0; go to CALC.
  - Op 4/5: latch a; go directly to DONE.
  - Op 6/7: ignored; stay in IDLE.
  - start is ignored while busy; no queueing.
- CALC:
  - One iteration per cycle, cnt 0..31.
  - Transition to DONE on the edge where cnt==31.
  - Multiply: 64-bit product accumulator, shift-add on LSB of multiplier.
  - Divide: 33-bit partial remainder, restoring subtract/shift.
- DONE:
  - Lasts one cycle: done=1; next state IDLE.
  - MULT/MULTU and DIV/DIVU: we=2'b11.
  - MTHI: we=2'b10, hilo_out={a,a}.
  - MTLO: we=2'b01, hilo_out={a,a}.
- Latency: start accepted at edge N.
  - Mul/div: DONE during the cycle after edge N+32; IDLE again after edge N+33.
  - MTHI/MTLO: DONE during the cycle after edge N; one cycle busy.
  - A new start is accepted at the earliest in the first IDLE cycle; no back-to-back acceptance from DONE.
- Sign fix, applied when forming hilo_out:
  - Signed product is negated (64-bit two's complement) if sign(a)^sign(b).
  - Signed quotient is negated if sign(a)^sign(b).
  - Signed remainder takes the sign of the dividend.
- Boundaries:
  - Divide by zero: no trap; result HI=a, LO=32'hFFFFFFFF for both DIV and DIVU; full normal latency.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Magnitude of 0x80000000 is handled as 33-bit/unsigned 2^31 without overflow.
- cancel:
  - In any state, next state is IDLE and we is forced to 00 in the same cycle, including DONE.
  - cancel has priority over start.
  - done must not pulse for a cancelled op.
- hilo_out holds its last value outside DONE; consumers must qualify it with we.

Decomposition:
- Shared defines file: op encodings (MULT..MTLO), FSM state encodings, WIDTH default.
- One natural sub-module, muldiv_div_iter, holding one restoring-division step: inputs partial remainder and quotient, outputs next values. It is combinational and instantiated inside the CALC datapath.
- Multiply stays inline.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> exactly one cycle with we=11, done=1, hilo_out=0xFFFFFFFE_00000001, 33 cycles after accept edge; busy high throughout.
2. MULT a=-3 (0xFFFFFFFD), b=5 -> hilo_out=0xFFFFFFFF_FFFFFFF1. DIV a=-7, b=2 -> HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3).
3. DIVU a=100, b=0 -> HI=0x00000064, LO=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> HI=0, LO=0x80000000.
4. MTHI a=0x00001234 -> next cycle we=10, hilo_out[63:32]=0x1234, busy high one cycle. MTLO a=0xABCD -> we=01, hilo_out[31:0]=0xABCD.
5. DIVU started, cancel at 10th CALC cycle -> IDLE next cycle, we/done never asserted. Repeat with cancel coinciding with DONE -> we=00. Repeat with rst mid-CALC -> all outputs 0.
6. start pulsed every cycle during a MULT -> only first accepted, exactly one done. start with op=6 -> no busy, no write.
